// File: rtl/difference_decoder_if.sv
// Bundle of the decoder's control, encoded-memory read port and output stream.
// The master modport is the decoder's view; slave is the memory/consumer side.
interface difference_decoder_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       mem_mode;
  logic [2:0] mem_index;
  logic [7:0] mem_data;
  logic       mem_sign;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_index;
  logic [7:0] out_value;

  modport master (
    input  start, mem_data, mem_sign, out_ready,
    output busy, done, mem_mode, mem_index, out_valid, out_index, out_value
  );

  modport slave (
    output start, mem_data, mem_sign, out_ready,
    input  busy, done, mem_mode, mem_index, out_valid, out_index, out_value
  );
endinterface

// File: rtl/difference_decoder.sv
// Scans the difference-encoded memory and rebuilds each value from magnitude, sign and
// a fixed mask ROM; start to first out_valid is 2+READ_LATENCY, holds output under backpressure.
module difference_decoder #(
  parameter int COUNT        = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  difference_decoder_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] LAST_IDX = 3'(COUNT - 1);
  localparam logic [1:0] WAIT_END = 2'(READ_LATENCY);

  logic [2:0] state_q,     state_d;
  logic [2:0] cnt_q,       cnt_d;
  logic [1:0] wait_q,      wait_d;
  logic [2:0] mem_index_q, mem_index_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] out_index_q, out_index_d;
  logic [7:0] out_value_q, out_value_d;
  logic [7:0] mask;

  function automatic logic [7:0] mask_of(input logic [2:0] idx);
    case (idx)
      3'd0:    mask_of = 8'h00;
      3'd1:    mask_of = 8'h55;
      3'd2:    mask_of = 8'hAA;
      3'd3:    mask_of = 8'h33;
      3'd4:    mask_of = 8'hCC;
      3'd5:    mask_of = 8'h0F;
      3'd6:    mask_of = 8'hF0;
      default: mask_of = 8'hFF;
    endcase
  endfunction

  assign mask = mask_of(cnt_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    mem_index_d = mem_index_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_value_d = out_value_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d   = 3'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Index is registered here, so the memory sees it from the first WAIT cycle.
        mem_index_d = cnt_q;
        wait_d      = 2'd0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_END) begin
          out_valid_d = 1'b1;
          out_index_d = cnt_q;
          out_value_d = bus.mem_sign ? (mask - bus.mem_data) : (mask + bus.mem_data);
          state_d     = S_OUT;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      wait_q      <= 2'd0;
      mem_index_q <= 3'd0;
      out_valid_q <= 1'b0;
      out_index_q <= 3'd0;
      out_value_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      mem_index_q <= mem_index_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_value_q <= out_value_d;
    end
  end

  assign bus.mem_mode  = 1'b1;
  assign bus.mem_index = mem_index_q;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;
  assign bus.out_value = out_value_q;

endmodule
